rgb_pwm_fader: RTL
==================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, the duty resolution per channel.
REQ-002 SHALL have parameter STEP_CYCLES, default 46875, clk cycles per fade step (12 MHz clock: full 0->255 fade in about 1 s).
REQ-003 SHALL have port clk  input  1  system clock, 12 MHz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port color_valid  input  1  new target colour offered.
REQ-006 SHALL have port color_ready  output  1  block accepts a target this cycle.
REQ-007 SHALL have ports color_r, color_g and color_b  input  PWM_BITS each  target duty per channel.
REQ-008 SHALL have port busy  output  1  fade in progress.
REQ-009 SHALL have ports RGB_R, RGB_G and RGB_B  output  1 each  PWM LED drive, active-high.

Function
REQ-010 SHALL contain a free-running PWM_BITS-bit period counter, incrementing every clk and wrapping 2^PWM_BITS-1 -> 0.
REQ-011 SHALL hold per channel a current duty (cur) and a target duty (tgt), each PWM_BITS wide.
REQ-012 SHALL drive each RGB_x output registered, high exactly when the period counter < the active duty for that channel.
REQ-013 SHALL make the active duty a copy of cur that is loaded only when the period counter wraps to 0, so no PWM period is glitched mid-cycle.
REQ-014 SHALL give duty 0 a constant-low output and duty 2^PWM_BITS-1 an output high for 255 of 256 cycles (PWM_BITS=8).
REQ-015 SHALL implement a two-state FSM, IDLE and FADE.
REQ-016 SHALL drive color_ready = (state==IDLE), combinationally from the state register only and never from color_valid.
REQ-017 SHALL complete a handshake when color_valid && color_ready; on that cycle tgt <= color_r/g/b.
REQ-018 SHALL go to FADE on a handshake if any new tgt differs from cur; otherwise state stays IDLE and nothing else changes.
REQ-019 SHALL, in FADE, run a step counter 0..STEP_CYCLES-1; at terminal count it wraps to 0 and each channel with cur != tgt moves cur one LSB toward tgt.
REQ-020 SHALL step channels independently; a channel already at target holds.
REQ-021 SHALL make the FSM return FADE -> IDLE on the step at which all three cur equal tgt, with color_ready high the next cycle.
REQ-022 SHALL prevent cur arithmetic from wrapping; a step is applied only when cur != tgt, so 0 and 2^PWM_BITS-1 are never crossed.
REQ-023 SHALL drive busy = (state==FADE).
REQ-024 SHALL ignore color_valid during FADE and hold the offered data un-consumed; the upstream source keeps it stable until accepted.
REQ-025 SHALL hold the step counter at 0 in IDLE, so the first step after acceptance occurs exactly STEP_CYCLES cycles later.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously clear state to IDLE, period counter, step counter, cur, tgt and active duties to 0, and RGB_R/G/B to 0.
REQ-027 SHALL have color_ready=1 and busy=0 while rst_n is low and on the first cycle after release.
REQ-028 SHALL, on reset asserted mid-fade, abandon the fade; after release all LEDs are off until a new target is accepted.

Structure
REQ-029 SHALL place the state enum (IDLE, FADE) and the default PWM_BITS constant in shared package rgb_pkg, which the colour-cycling and fader blocks both import.
REQ-030 SHALL contain sub-module pwm_channel (shadow-duty register loaded at wrap, compare, registered output), instantiated three times; fade control stays in the top module.

Verification (STEP_CYCLES=4, PWM_BITS=8)
REQ-031 Reset then idle: release rst_n -> RGB_* low for 1000 cycles, color_ready=1, busy=0.
REQ-032 Accept (255,0,0): handshake -> busy next cycle; cur_r increments every 4 cycles, reaching 255 after 1020 cycles; busy drops; RGB_R high for 255 of each 256 cycles.
REQ-033 Mixed fade (10,0,0) -> (8,3,10): R falls, G and B rise independently; G settles after 3 steps, R holds after 2 steps, idle after 10 steps (40 cycles).
REQ-034 Valid during FADE: new colour offered mid-fade -> color_ready stays 0, no tgt change; accepted on the first IDLE cycle.
REQ-035 Same target: offer the current colour in IDLE -> handshake completes, busy stays 0, no duty change.
REQ-036 Reset mid-fade: assert rst_n low asynchronously at step 5 of a fade -> all outputs 0 immediately; after release, idle with color_ready=1.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB colour blocks: fader state encoding and
// the default duty resolution.
package rgb_pkg;

  localparam int PWM_BITS_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output channel. The requested duty is copied into a shadow
// register only as the period counter wraps, so a period is never cut short
// or stretched by a duty change; the compare result is registered.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] period_cnt,
  input  logic                period_wrap,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] active_q, active_d;
  logic                pwm_q, pwm_d;

  // Shadow duty reload at the wrap and the period compare.
  always_comb begin
    active_d = active_q;
    if (period_wrap) begin
      active_d = duty;
    end
    pwm_d = (period_cnt < active_q);
  end

  // Shadow duty and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel LED fader. A target colour is accepted while idle; each
// channel's current duty then walks one LSB toward its target every
// STEP_CYCLES clocks until all three match, after which the block idles.
module rgb_pwm_fader
  import rgb_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEFAULT,
  parameter int STEP_CYCLES = 46875
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  fade_state_e                  state_q, state_d;
  logic [PWM_BITS-1:0]          period_q, period_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic [2:0][PWM_BITS-1:0]     cur_q, cur_d;
  logic [2:0][PWM_BITS-1:0]     tgt_q, tgt_d;
  logic [2:0][PWM_BITS-1:0]     color_in;
  logic [2:0]                   pwm_vec;
  logic                         period_wrap;

  // Move one LSB toward the target; equal values hold, so no wrap can occur.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                      input logic [PWM_BITS-1:0] t);
    if (c < t) begin
      return c + 1'b1;
    end else if (c > t) begin
      return c - 1'b1;
    end
    return c;
  endfunction

  assign color_in    = {color_b, color_g, color_r};
  assign color_ready = (state_q == IDLE);
  assign busy        = (state_q == FADE);
  assign period_wrap = (period_q == '1);

  // Free-running PWM period counter.
  always_comb begin
    period_d = period_q + 1'b1;
  end

  // Fade FSM: accept targets while idle, step duties while fading.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        step_d = '0;
        if (color_valid) begin
          tgt_d = color_in;
          if (color_in != cur_q) begin
            state_d = FADE;
          end
        end
      end
      FADE: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          for (int i = 0; i < 3; i++) begin
            cur_d[i] = step_toward(cur_q[i], tgt_q[i]);
          end
          if (cur_d == tgt_q) begin
            state_d = IDLE;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and duty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      step_q   <= '0;
      cur_q    <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      step_q   <= step_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      pwm_channel #(
        .PWM_BITS(PWM_BITS)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_cnt (period_q),
        .period_wrap(period_wrap),
        .duty       (cur_q[gi]),
        .pwm_out    (pwm_vec[gi])
      );
    end
  endgenerate

  assign RGB_R = pwm_vec[0];
  assign RGB_G = pwm_vec[1];
  assign RGB_B = pwm_vec[2];

endmodule
